// File: rtl/router_vc_input_unit.sv
// router_vc_input_unit
//   Input unit of a NoC router tile: one input link feeding NUM_VC virtual
//   channel flit FIFOs. Each VC runs a small routing FSM (IDLE/ROUTE/ACTIVE)
//   that performs XY dimension-order routing on head flits, raises a one-hot
//   output-port request to the switch allocator and returns a credit (oack)
//   one cycle after every pop.
//
//   Optional feature macro: ROUTER_VC_ERR_CHK_EN
//     defined   -> ovf_err port present, sticky error on dropped writes,
//                  writes to a non-existent VC and stray non-head flits.
//     undefined -> no ovf_err port; the same events are silently dropped.
//
//   Handshake: a flit on idata is taken when ivalid is high and the target VC
//   has room (ordy[ivch]) or is being popped in the same cycle; a VC head is
//   consumed when grant[v] is high while req[v*5+:5] is non-zero; every pop
//   (including stray drops) is answered with exactly one oack[v] pulse on the
//   following cycle.
//
//   Flit format: [DATA_W-1:DATA_W-2] type (00 body, 01 head, 10 tail,
//   11 head+tail); head flits carry dest_x in [POS_W-1:0] and dest_y in
//   [2*POS_W-1:POS_W]. Output ports: 0 local, 1 +x, 2 -x, 3 +y, 4 -y.
module router_vc_input_unit #(
    parameter int DATA_W = 35,
    parameter int NUM_VC = 2,
    parameter int DEPTH  = 4,
    parameter int POS_W  = 2,
    parameter int VCID_W = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [POS_W-1:0]         my_xpos,
    input  logic [POS_W-1:0]         my_ypos,
    input  logic [DATA_W-1:0]        idata,
    input  logic                     ivalid,
    input  logic [VCID_W-1:0]        ivch,
    output logic [NUM_VC-1:0]        ordy,
    output logic [NUM_VC-1:0]        oack,
    output logic [NUM_VC*5-1:0]      req,
    output logic [NUM_VC*DATA_W-1:0] odata,
    input  logic [NUM_VC-1:0]        grant
`ifdef ROUTER_VC_ERR_CHK_EN
    ,
    output logic                     ovf_err
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [4:0] PORT_LOCAL = 5'b00001;
    localparam logic [4:0] PORT_XPOS  = 5'b00010;
    localparam logic [4:0] PORT_XNEG  = 5'b00100;
    localparam logic [4:0] PORT_YPOS  = 5'b01000;
    localparam logic [4:0] PORT_YNEG  = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUTE  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Per-VC storage and control state
    logic [DATA_W-1:0] r_mem    [NUM_VC][DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr [NUM_VC];
    logic [PTR_W-1:0]  r_rd_ptr [NUM_VC];
    logic [CNT_W-1:0]  r_count  [NUM_VC];
    state_t            r_state  [NUM_VC];
    logic [4:0]        r_route  [NUM_VC];
    logic [NUM_VC-1:0] r_oack;

    // Per-VC combinational decode
    logic [DATA_W-1:0] w_head   [NUM_VC];
    logic [NUM_VC-1:0] w_empty;
    logic [NUM_VC-1:0] w_full;
    logic [NUM_VC-1:0] w_is_head;
    logic [NUM_VC-1:0] w_is_tail;
    logic [NUM_VC-1:0] w_active;
    logic [NUM_VC-1:0] w_stray;
    logic [NUM_VC-1:0] w_pop;
    logic [NUM_VC-1:0] w_sel;
    logic [NUM_VC-1:0] w_push;

`ifdef ROUTER_VC_ERR_CHK_EN
    logic [NUM_VC-1:0] w_drop;
    logic              w_bad_vc;
    logic              r_ovf_err;
`endif

    // XY dimension-order routing: resolve X first, then Y, else eject locally.
    // All coordinate comparisons are unsigned.
    function automatic logic [4:0] xy_route(
        input logic [2*POS_W-1:0] dest,
        input logic [POS_W-1:0]   mx,
        input logic [POS_W-1:0]   my
    );
        logic [POS_W-1:0] dx;
        logic [POS_W-1:0] dy;
        dx = dest[POS_W-1:0];
        dy = dest[2*POS_W-1:POS_W];
        if (dx > mx) begin
            return PORT_XPOS;
        end else if (dx < mx) begin
            return PORT_XNEG;
        end else if (dy > my) begin
            return PORT_YPOS;
        end else if (dy < my) begin
            return PORT_YNEG;
        end
        return PORT_LOCAL;
    endfunction

    // Head-of-FIFO decode, pop/push qualification and output drive per VC
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            w_head[v]    = r_mem[v][r_rd_ptr[v]];
            w_empty[v]   = (r_count[v] == '0);
            w_full[v]    = (r_count[v] == CNT_W'(DEPTH));
            w_is_head[v] = w_head[v][DATA_W-2];
            w_is_tail[v] = w_head[v][DATA_W-1];
            w_active[v]  = (r_state[v] == ST_ACTIVE) && !w_empty[v];
            // A body/tail flit reaching the head of an idle VC has no route;
            // it is discarded so the VC cannot deadlock behind it.
            w_stray[v]   = (r_state[v] == ST_IDLE) && !w_empty[v] && !w_is_head[v];
            w_pop[v]     = w_stray[v] || (w_active[v] && grant[v]);
            w_sel[v]     = ivalid && (32'(ivch) == v);
            // A pop in the same cycle frees the slot a full FIFO needs.
            w_push[v]    = w_sel[v] && (!w_full[v] || w_pop[v]);

            ordy[v]               = !w_full[v];
            oack[v]               = r_oack[v];
            req[v*5 +: 5]         = w_active[v] ? r_route[v] : 5'b00000;
            odata[v*DATA_W +: DATA_W] = w_head[v];
        end
    end

`ifdef ROUTER_VC_ERR_CHK_EN
    // Error events: writes lost to a full VC and writes to a VC that does not exist
    always_comb begin
        w_bad_vc = ivalid && (32'(ivch) >= NUM_VC);
        for (int v = 0; v < NUM_VC; v++) begin
            w_drop[v] = w_sel[v] && w_full[v] && !w_pop[v];
        end
    end
`endif

    // Flit storage; contents need no reset because occupancy is tracked by r_count
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (!rst && w_push[v]) begin
                r_mem[v][r_wr_ptr[v]] <= idata;
            end
        end
    end

    // FIFO pointers, occupancy and the one-cycle-delayed credit pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_count[v]  <= '0;
            end
            r_oack <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (w_push[v]) begin
                    r_wr_ptr[v] <= r_wr_ptr[v] + PTR_W'(1);
                end
                if (w_pop[v]) begin
                    r_rd_ptr[v] <= r_rd_ptr[v] + PTR_W'(1);
                end
                r_count[v] <= r_count[v] + CNT_W'(w_push[v]) - CNT_W'(w_pop[v]);
            end
            r_oack <= w_pop;
        end
    end

    // Per-VC wormhole FSM: wait for a head, latch its route, hold it until the tail leaves
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                r_state[v] <= ST_IDLE;
                r_route[v] <= 5'b00000;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                case (r_state[v])
                    ST_IDLE: begin
                        if (!w_empty[v] && w_is_head[v]) begin
                            r_state[v] <= ST_ROUTE;
                        end
                    end
                    ST_ROUTE: begin
                        r_route[v] <= xy_route(w_head[v][2*POS_W-1:0], my_xpos, my_ypos);
                        r_state[v] <= ST_ACTIVE;
                    end
                    ST_ACTIVE: begin
                        if (w_pop[v] && w_is_tail[v]) begin
                            r_state[v] <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state[v] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef ROUTER_VC_ERR_CHK_EN
    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
        end else if ((|w_drop) || w_bad_vc || (|w_stray)) begin
            r_ovf_err <= 1'b1;
        end
    end

    assign ovf_err = r_ovf_err;
`endif

endmodule
